// File: rtl/riscv_icache_nway.sv
// N-way set-associative instruction cache with round-robin replacement, two-line spanning fetch and fence.i flush.
// Optional hit/miss counters are enabled by defining RISCV_ICACHE_PERF_EN.
module riscv_icache_nway #(
   parameter int WAYS       = 2,
   parameter int SETS       = 64,
   parameter int LINE_BYTES = 16,
   parameter int PADDR_W    = 64
) (
   input  logic                                    i_riscv_icache_clk,
   input  logic                                    i_riscv_icache_rst_n,
   input  logic [PADDR_W-1:0]                      i_riscv_icache_phys_addr,
   input  logic                                    i_riscv_icache_flush,
   input  logic                                    i_riscv_icache_mem_ready,
   input  logic [LINE_BYTES*8-1:0]                 i_riscv_icache_mem_data_out,
   output logic [PADDR_W-$clog2(LINE_BYTES)-1:0]   o_riscv_icache_mem_addr,
   output logic                                    o_riscv_icache_mem_rden,
   output logic [31:0]                             o_riscv_icache_cpu_instr_out,
`ifdef RISCV_ICACHE_PERF_EN
   output logic [31:0]                             o_riscv_icache_hit_cnt,
   output logic [31:0]                             o_riscv_icache_miss_cnt,
`endif
   output logic                                    o_riscv_icache_cpu_stall
);

   localparam int OFF = $clog2(LINE_BYTES);
   localparam int IDX = $clog2(SETS);
   localparam int LA  = PADDR_W - OFF;
   localparam int TAG = LA - IDX;
   localparam int LW  = LINE_BYTES * 8;
   localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, MISS_LO, MISS_HI} state_t;

   state_t state_reg, state_next;

   logic [SETS-1:0] valid_reg [WAYS];
   logic [TAG-1:0]  tag_reg   [WAYS][SETS];
   logic [LW-1:0]   data_reg  [WAYS][SETS];
   logic [WB-1:0]   ptr_reg   [SETS];

   logic [LA-1:0]   lo_line, hi_line, fill_line;
   logic [IDX-1:0]  lo_idx, hi_idx, fill_idx;
   logic [TAG-1:0]  lo_tag, hi_tag, fill_tag;
   logic [OFF-1:0]  off;
   logic            span, hit_lo, hit_hi, required, fill_en;
   logic [WAYS-1:0] hit_lo_vec, hit_hi_vec, inv_vec;
   logic [LW-1:0]   lo_data, hi_data;
   logic [2*LW-1:0] window;
   logic [WB-1:0]   victim;

   assign lo_line   = i_riscv_icache_phys_addr[PADDR_W-1:OFF];
   assign hi_line   = lo_line + 1'b1;
   assign off       = i_riscv_icache_phys_addr[OFF-1:0];
   assign span      = (off > OFF'(LINE_BYTES - 4));
   assign lo_idx    = lo_line[IDX-1:0];
   assign hi_idx    = hi_line[IDX-1:0];
   assign lo_tag    = lo_line[LA-1:IDX];
   assign hi_tag    = hi_line[LA-1:IDX];
   assign fill_line = (state_reg == MISS_HI) ? hi_line : lo_line;
   assign fill_idx  = fill_line[IDX-1:0];
   assign fill_tag  = fill_line[LA-1:IDX];

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign hit_lo_vec[gi] = valid_reg[gi][lo_idx] && (tag_reg[gi][lo_idx] == lo_tag);
         assign hit_hi_vec[gi] = valid_reg[gi][hi_idx] && (tag_reg[gi][hi_idx] == hi_tag);
         assign inv_vec[gi]    = !valid_reg[gi][fill_idx];
      end
   endgenerate

   assign hit_lo   = |hit_lo_vec;
   assign hit_hi   = |hit_hi_vec;
   assign required = hit_lo && (!span || hit_hi);

   // A line is only ever filled on a miss, so at most one way hits and OR-merging is safe.
   always_comb begin
      lo_data = '0;
      hi_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_lo_vec[w]) lo_data = lo_data | data_reg[w][lo_idx];
         if (hit_hi_vec[w]) hi_data = hi_data | data_reg[w][hi_idx];
      end
   end

   assign window = {hi_data, lo_data};
   assign o_riscv_icache_cpu_stall     = !required || (state_reg != IDLE);
   assign o_riscv_icache_cpu_instr_out = o_riscv_icache_cpu_stall ? 32'd0 : window[{off, 3'b000} +: 32];
   assign o_riscv_icache_mem_rden      = (state_reg != IDLE);
   assign o_riscv_icache_mem_addr      = (state_reg != IDLE) ? fill_line : '0;

   // Lowest invalid way wins; a full set falls back to its round-robin pointer.
   always_comb begin
      victim = ptr_reg[fill_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (inv_vec[w]) victim = WB'(w);
      end
   end

   assign fill_en = (state_reg != IDLE) && i_riscv_icache_mem_ready && !i_riscv_icache_flush;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (!hit_lo)              state_next = MISS_LO;
            else if (span && !hit_hi) state_next = MISS_HI;
         end
         MISS_LO, MISS_HI: begin
            if (i_riscv_icache_mem_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (i_riscv_icache_flush) state_next = IDLE;
   end

   always_ff @(posedge i_riscv_icache_clk or negedge i_riscv_icache_rst_n) begin
      if (!i_riscv_icache_rst_n) begin
         state_reg <= IDLE;
         for (int w = 0; w < WAYS; w++) valid_reg[w] <= '0;
         for (int s = 0; s < SETS; s++) ptr_reg[s] <= '0;
      end else begin
         state_reg <= state_next;
         if (i_riscv_icache_flush) begin
            for (int w = 0; w < WAYS; w++) valid_reg[w] <= '0;
            for (int s = 0; s < SETS; s++) ptr_reg[s] <= '0;
         end else if (fill_en) begin
            valid_reg[victim][fill_idx] <= 1'b1;
            ptr_reg[fill_idx] <= (ptr_reg[fill_idx] == WB'(WAYS - 1)) ? '0 : ptr_reg[fill_idx] + 1'b1;
         end
      end
   end

   always_ff @(posedge i_riscv_icache_clk) begin
      if (fill_en) begin
         tag_reg[victim][fill_idx]  <= fill_tag;
         data_reg[victim][fill_idx] <= i_riscv_icache_mem_data_out;
      end
   end

`ifdef RISCV_ICACHE_PERF_EN
   always_ff @(posedge i_riscv_icache_clk or negedge i_riscv_icache_rst_n) begin
      if (!i_riscv_icache_rst_n) begin
         o_riscv_icache_hit_cnt  <= '0;
         o_riscv_icache_miss_cnt <= '0;
      end else begin
         if ((state_reg == IDLE) && required && (o_riscv_icache_hit_cnt != 32'hFFFF_FFFF))
            o_riscv_icache_hit_cnt <= o_riscv_icache_hit_cnt + 1'b1;
         if ((state_reg == IDLE) && (state_next != IDLE) && (o_riscv_icache_miss_cnt != 32'hFFFF_FFFF))
            o_riscv_icache_miss_cnt <= o_riscv_icache_miss_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_riscv_icache_nway.sv
// Scoreboard bench for riscv_icache_nway: a CPU driver, a memory responder and an instruction monitor,
// checked against a line-level cache model and a hashed byte memory.
module tb_riscv_icache_nway;
   localparam int WAYS = 2, SETS = 64, LB = 16, PW = 64, OFF = 4, LA = PW - OFF, LW = LB * 8;

   logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, mem_ready = 1'b0;
   logic [PW-1:0] addr = '0;
   logic [LW-1:0] mem_data = '0;
   logic [LA-1:0] mem_addr;
   logic          rden, stall;
   logic [31:0]   instr;
`ifdef RISCV_ICACHE_PERF_EN
   logic [31:0]   hit_cnt, miss_cnt;
`endif

   riscv_icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LB), .PADDR_W(PW)) dut (
      .i_riscv_icache_clk(clk),
      .i_riscv_icache_rst_n(rst_n),
      .i_riscv_icache_phys_addr(addr),
      .i_riscv_icache_flush(flush),
      .i_riscv_icache_mem_ready(mem_ready),
      .i_riscv_icache_mem_data_out(mem_data),
      .o_riscv_icache_mem_addr(mem_addr),
      .o_riscv_icache_mem_rden(rden),
      .o_riscv_icache_cpu_instr_out(instr),
`ifdef RISCV_ICACHE_PERF_EN
      .o_riscv_icache_hit_cnt(hit_cnt),
      .o_riscv_icache_miss_cnt(miss_cnt),
`endif
      .o_riscv_icache_cpu_stall(stall)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int done_cnt = 0, target = 0, miss_total = 0, fetch_total = 0;
   bit active = 0, auto_mem = 0, timed_out = 0;
   logic [31:0]   exp_q[$];
   logic [LA-1:0] req_q[$];

   // Line-level model: which lines each set holds, plus its round-robin pointer.
   bit            mv[SETS][WAYS];
   logic [LA-1:0] mt[SETS][WAYS];
   int            mptr[SETS];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mbyte(input logic [PW-1:0] a);
      logic [31:0] h;
      h = a[31:0] * 32'h9E37_79B1 + 32'h0123_4567;
      return h[31:24] ^ h[15:8];
   endfunction

   function automatic logic [LW-1:0] line_data(input logic [LA-1:0] la);
      logic [LW-1:0] r;
      for (int b = 0; b < LB; b++) r[b*8 +: 8] = mbyte({la, 4'b0000} + PW'(b));
      return r;
   endfunction

   task automatic model_access(input logic [LA-1:0] la, output bit miss);
      int s, v;
      s = int'(la % SETS);
      miss = 1;
      for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == la) miss = 0;
      if (miss) begin
         v = -1;
         for (int w = 0; w < WAYS; w++) if (!mv[s][w] && v < 0) v = w;
         if (v < 0) v = mptr[s];
         mv[s][v] = 1;
         mt[s][v] = la;
         mptr[s]  = (mptr[s] + 1) % WAYS;
      end
   endtask

   task automatic issue(input logic [PW-1:0] a);
      logic [LA-1:0] lo;
      bit m;
      lo = a[PW-1:OFF];
      exp_q.push_back({mbyte(a + 3), mbyte(a + 2), mbyte(a + 1), mbyte(a)});
      model_access(lo, m);
      if (m) begin req_q.push_back(lo); miss_total++; end
      if (a[3:0] > 4'd12) begin
         model_access(lo + 1'b1, m);
         if (m) begin req_q.push_back(lo + 1'b1); miss_total++; end
      end
      fetch_total++;
      target++;
      addr = a;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         if (done_cnt >= target) return;
      end
      checks++; errors++; timed_out = 1;
      $display("FAIL fetch_timeout: got done=%0d expected %0d", done_cnt, target);
   endtask

   // Instruction monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (active && rst_n && !stall) begin
            if (exp_q.size() == 0) check("unexpected_fetch", 64'(instr), 64'hDEAD);
            else check("instr", 64'(instr), 64'(exp_q.pop_front()));
            done_cnt++;
         end
      end
   end

   // Memory responder: random latency, stray mem_ready pulses while idle.
   initial begin
      logic [LA-1:0] cur;
      int  wl;
      bit  serving;
      serving = 0; wl = 0; cur = '0;
      forever begin
         @(negedge clk);
         if (auto_mem) begin
            mem_ready = 1'b0;
            if (rden) begin
               if (!serving) begin
                  serving = 1;
                  cur = mem_addr;
                  if (req_q.size() == 0) check("unexpected_req", 64'(mem_addr), 64'hDEAD);
                  else check("req_addr", 64'(mem_addr), 64'(req_q.pop_front()));
                  wl = $urandom_range(0, 3);
               end else begin
                  check("req_stable", 64'(mem_addr), 64'(cur));
               end
               if (wl == 0) begin
                  mem_ready = 1'b1;
                  mem_data  = line_data(cur);
                  serving   = 0;
               end else wl--;
            end else if ($urandom_range(0, 3) == 0) begin
               mem_ready = 1'b1;
               mem_data  = {4{$urandom}};
            end
         end
      end
   end

   initial begin
      logic [PW-1:0] dir_addr[6];
      logic [PW-1:0] a;
      int idx;
      dir_addr = '{64'h1000, 64'h200E, 64'h5004, 64'h9008, 64'h1000, 64'h5000};
      addr = 64'h1000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", 64'(stall), 64'd1);
      check("rst_rden", 64'(rden), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);

      active = 1; auto_mem = 1;
      issue(dir_addr[0]);
      rst_n = 1'b1;
      wait_done();
      for (int i = 1; i < 6 && !timed_out; i++) begin
         #1 issue(dir_addr[i]);
         wait_done();
      end
      for (int i = 0; i < 300 && !timed_out; i++) begin
         idx = $urandom_range(0, 3);
         if (idx == 3) idx = SETS - 1;
         a = (PW'($urandom_range(0, 5)) << 10) | (PW'(idx) << 4) | PW'($urandom_range(0, 15));
         #1 issue(a);
         wait_done();
      end
      #1;
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      check("req_q_drained", 64'(req_q.size()), 64'd0);
`ifdef RISCV_ICACHE_PERF_EN
      check("hit_cnt", 64'(hit_cnt), 64'(fetch_total));
      check("miss_cnt", 64'(miss_cnt), 64'(miss_total));
`endif

      // Flush in the same cycle as mem_ready must discard the fill.
      active = 0; auto_mem = 0;
      @(negedge clk);
      mem_ready = 1'b0;
      @(posedge clk); #1 addr = 64'h3000;
      for (int i = 0; i < 10 && !rden; i++) @(negedge clk);
      check("flush_req_addr", 64'(mem_addr), 64'h300);
      flush = 1'b1; mem_ready = 1'b1; mem_data = line_data(60'h300);
      @(posedge clk); #1 flush = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      check("flush_rden_idle", 64'(rden), 64'd0);
      check("flush_stall", 64'(stall), 64'd1);
      @(negedge clk);
      check("flush_rerequest", 64'({rden, mem_addr}), 64'({1'b1, 60'h300}));
      mem_ready = 1'b1; mem_data = line_data(60'h300);
      @(posedge clk); #1 mem_ready = 1'b0;
      @(negedge clk);
      check("flush_refill_stall", 64'(stall), 64'd0);
      check("flush_refill_instr", 64'(instr),
            64'({mbyte(64'h3003), mbyte(64'h3002), mbyte(64'h3001), mbyte(64'h3000)}));

      // Reset in the middle of a hi-line refill.
      @(posedge clk); #1 addr = 64'h300E;
      for (int i = 0; i < 10 && !rden; i++) @(negedge clk);
      check("hi_req_addr", 64'(mem_addr), 64'h301);
      rst_n = 1'b0;
      #1;
      check("arst_rden", 64'(rden), 64'd0);
      check("arst_stall", 64'(stall), 64'd1);
      check("arst_instr", 64'(instr), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; addr = 64'h3000;
      @(negedge clk);
      check("post_rst_stall", 64'(stall), 64'd1);
      @(negedge clk);
      check("post_rst_miss", 64'({rden, mem_addr}), 64'({1'b1, 60'h300}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
